// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller and the data memory:
// dm_type access codes and the controller FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] DMT_W  = 3'b000;
  localparam logic [2:0] DMT_H  = 3'b100;
  localparam logic [2:0] DMT_HU = 3'b101;
  localparam logic [2:0] DMT_B  = 3'b110;
  localparam logic [2:0] DMT_BU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic type_known(input logic [2:0] dtype);
    return (dtype == DMT_W) || dtype[2];
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational legality/alignment check for one memory request.
// LSU_MISALIGN_TRAP_EN makes misaligned accesses illegal; otherwise the address is force-aligned.
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  dtype,
  input  logic [31:0] addr,
  output logic        illegal,
  output logic [31:0] masked_addr
);

  logic bad_type;
  logic misaligned;

  always_comb begin
    bad_type    = !type_known(dtype) || (we && (dtype == DMT_HU || dtype == DMT_BU));
    misaligned  = ((dtype == DMT_H || dtype == DMT_HU) && addr[0]) ||
                  ((dtype == DMT_W) && (addr[1:0] != 2'b00));
    masked_addr = addr;
`ifdef LSU_MISALIGN_TRAP_EN
    illegal     = bad_type || misaligned;
`else
    illegal     = bad_type;
    if (misaligned) begin
      if (dtype == DMT_W) masked_addr[1:0] = 2'b00;
      else                masked_addr[0]   = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding data-memory access, held for WAIT_CYCLES.
// Misalignment handling depends on LSU_MISALIGN_TRAP_EN (see lsu_align_chk).
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_IDLE | req_ready high, waiting for a request
//  ST_HOLD | memory access driven stable, down-counter running
//  ST_RESP | response presented until rsp_ready
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dm_w,
  output logic [2:0]  dm_type,
  output logic [31:0] a1,
  output logic [31:0] wd,
  input  logic [31:0] rd1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int                 CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        type_q;
  logic [31:0]       addr_q, wdata_q;
  logic              illegal;
  logic [31:0]       masked_addr;
  logic              accept;

  lsu_align_chk u_chk (
    .we          (req_we),
    .dtype       (req_type),
    .addr        (req_addr),
    .illegal     (illegal),
    .masked_addr (masked_addr)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = illegal ? ST_RESP : ST_HOLD;
      ST_HOLD: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is gated by reset so nothing can be offered while reset is held
  always_comb begin
    req_ready = (state == ST_IDLE) && reset;
    dm_w      = (state == ST_HOLD) && we_q;
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      type_q    <= DMT_W;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      we_q      <= req_we;
      type_q    <= req_type;
      addr_q    <= masked_addr;
      wdata_q   <= req_wdata;
      cnt       <= illegal ? '0 : CNT_LOAD;
      rsp_rdata <= '0;
      rsp_err   <= illegal;
    end else if (state == ST_HOLD) begin
      if (cnt == '0) begin
        if (!we_q) rsp_rdata <= rd1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign a1      = addr_q;
  assign dm_type = type_q;
  assign wd      = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a byte-array data memory and a
// request-level reference model; honours LSU_MISALIGN_TRAP_EN like the design.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        dm_w;
  logic [2:0]  dm_type;
  logic [31:0] a1, wd, rd1;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int passed = 0;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  logic        clr_mem;
  logic [5:0]  ix0, ix1, ix2, ix3;
  logic [31:0] raw;

  lsu_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .dm_w      (dm_w),
    .dm_type   (dm_type),
    .a1        (a1),
    .wd        (wd),
    .rd1       (rd1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Data memory: little-endian bytes, read data extended per dm_type
  assign ix0 = a1[5:0];
  assign ix1 = a1[5:0] + 6'd1;
  assign ix2 = a1[5:0] + 6'd2;
  assign ix3 = a1[5:0] + 6'd3;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (dm_w) begin
      mem[ix0] <= wd[7:0];
      if (dm_type != DMT_B && dm_type != DMT_BU) mem[ix1] <= wd[15:8];
      if (dm_type == DMT_W) begin
        mem[ix2] <= wd[23:16];
        mem[ix3] <= wd[31:24];
      end
    end
  end

  always_comb begin
    raw = {mem[ix3], mem[ix2], mem[ix1], mem[ix0]};
    case (dm_type)
      DMT_H:   rd1 = {{16{raw[15]}}, raw[15:0]};
      DMT_HU:  rd1 = {16'h0000, raw[15:0]};
      DMT_B:   rd1 = {{24{raw[7]}}, raw[7:0]};
      DMT_BU:  rd1 = {24'h000000, raw[7:0]};
      default: rd1 = raw;
    endcase
  end

  // Reference: what one request should do, from access size and sign rules
  task automatic ref_exec(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                          output int lat, output int dmw, output logic [31:0] eff);
    int size;
    logic sgn, mis;
    logic [31:0] v;
    logic [5:0] ix;
    err = 1'b0; rdata = '0; lat = 1; dmw = 0; size = 1; sgn = 1'b0;
    case (typ)
      3'b000: size = 4;
      3'b100: begin size = 2; sgn = 1'b1; end
      3'b101: size = 2;
      3'b110: begin size = 1; sgn = 1'b1; end
      3'b111: size = 1;
      default: err = 1'b1;
    endcase
    if (we && (typ == 3'b101 || typ == 3'b111)) err = 1'b1;
    mis = (addr % 32'(size)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) err = 1'b1;
    eff = addr;
`else
    eff = mis ? addr - (addr % 32'(size)) : addr;
`endif
    if (err) return;
    lat = W + 1;
    if (we) begin
      dmw = W;
      for (int i = 0; i < size; i++) begin
        ix = 6'((eff + 32'(i)) % 64);
        ref_mem[ix] = wdata[8*i +: 8];
      end
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) begin
        ix = 6'((eff + 32'(i)) % 64);
        v[8*i +: 8] = ref_mem[ix];
      end
      if (sgn && v[8*size-1]) for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
      rdata = v;
    end
  endtask

  // Drive one request; returns at the first cycle rsp_valid is seen (lat = -1 on timeout)
  task automatic run_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int dmw,
                         output logic err, output logic [31:0] rdata, output logic [31:0] a1o);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; dmw = 0; a1o = a1;
    while (!rsp_valid && lat < 40) begin
      if (dm_w) dmw++;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    err = rsp_err; rdata = rsp_rdata;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clr_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else passed++;
    checks++; if ({dm_w, dm_type, a1, wd} !== '0) $display("FAIL reset_dm: got dm_w=%b type=%b a1=%h wd=%h expected all 0", dm_w, dm_type, a1, wd); else passed++;
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h expected all 0", rsp_valid, rsp_err, rsp_rdata); else passed++;
    clr_mem = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_word();
    int lat, dmw, elat, edmw; logic err, eerr; logic [31:0] rd, erd, a1o, eff;
    ref_exec(1'b1, DMT_W, 32'h8, 32'hDEADBEEF, eerr, erd, elat, edmw, eff);
    run_req(1'b1, DMT_W, 32'h8, 32'hDEADBEEF, lat, dmw, err, rd, a1o);
    checks++; if (lat !== elat) $display("FAIL word_st_latency: got %0d expected %0d", lat, elat); else passed++;
    checks++; if (dmw !== edmw) $display("FAIL word_st_dm_w_cycles: got %0d expected %0d", dmw, edmw); else passed++;
    checks++; if (a1o !== 32'h8) $display("FAIL word_st_a1: got %h expected 00000008", a1o); else passed++;
    checks++; if ({err, rd} !== {1'b0, 32'h0}) $display("FAIL word_st_rsp: got err=%b rdata=%h expected err=0 rdata=0", err, rd); else passed++;
    finish_rsp();
    ref_exec(1'b0, DMT_W, 32'h8, 32'h0, eerr, erd, elat, edmw, eff);
    run_req(1'b0, DMT_W, 32'h8, 32'h0, lat, dmw, err, rd, a1o);
    checks++; if (lat !== 6) $display("FAIL word_ld_latency: got %0d expected 6", lat); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL word_ld_rdata: got %h expected deadbeef", rd); else passed++;
    checks++; if (dmw !== 0) $display("FAIL word_ld_dm_w_cycles: got %0d expected 0", dmw); else passed++;
    finish_rsp();
  endtask

  task automatic test_byte();
    int lat, dmw, elat, edmw; logic err, eerr; logic [31:0] rd, erd, a1o, eff;
    ref_exec(1'b1, DMT_B, 32'h5, 32'h5A5A5AAA, eerr, erd, elat, edmw, eff);
    run_req(1'b1, DMT_B, 32'h5, 32'h5A5A5AAA, lat, dmw, err, rd, a1o);
    finish_rsp();
    ref_exec(1'b0, DMT_BU, 32'h5, 32'h0, eerr, erd, elat, edmw, eff);
    run_req(1'b0, DMT_BU, 32'h5, 32'h0, lat, dmw, err, rd, a1o);
    checks++; if (rd !== 32'h000000AA) $display("FAIL byte_ld_bu: got %h expected 000000aa", rd); else passed++;
    finish_rsp();
    ref_exec(1'b0, DMT_B, 32'h5, 32'h0, eerr, erd, elat, edmw, eff);
    run_req(1'b0, DMT_B, 32'h5, 32'h0, lat, dmw, err, rd, a1o);
    checks++; if (rd !== 32'hFFFFFFAA) $display("FAIL byte_ld_b: got %h expected ffffffaa", rd); else passed++;
    finish_rsp();
  endtask

  task automatic test_misalign();
    int lat, dmw, elat, edmw; logic err, eerr; logic [31:0] rd, erd, a1o, eff;
    ref_exec(1'b1, DMT_W, 32'h0, 32'h88993344, eerr, erd, elat, edmw, eff);
    run_req(1'b1, DMT_W, 32'h0, 32'h88993344, lat, dmw, err, rd, a1o);
    finish_rsp();
    ref_exec(1'b0, DMT_H, 32'h3, 32'h0, eerr, erd, elat, edmw, eff);
    run_req(1'b0, DMT_H, 32'h3, 32'h0, lat, dmw, err, rd, a1o);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (err !== 1'b1) $display("FAIL misalign_err: got %b expected 1", err); else passed++;
    checks++; if (lat !== 1) $display("FAIL misalign_latency: got %0d expected 1", lat); else passed++;
`else
    checks++; if (err !== 1'b0) $display("FAIL misalign_err: got %b expected 0", err); else passed++;
    checks++; if (a1o !== 32'h2) $display("FAIL misalign_a1: got %h expected 00000002", a1o); else passed++;
    checks++; if (rd !== 32'hFFFF8899) $display("FAIL misalign_rdata: got %h expected ffff8899", rd); else passed++;
`endif
    checks++; if (dmw !== 0) $display("FAIL misalign_dm_w_cycles: got %0d expected 0", dmw); else passed++;
    finish_rsp();
  endtask

  task automatic test_illegal();
    int lat, dmw, elat, edmw; logic err, eerr; logic [31:0] rd, erd, a1o, eff;
    ref_exec(1'b1, DMT_HU, 32'h8, 32'h12345678, eerr, erd, elat, edmw, eff);
    run_req(1'b1, DMT_HU, 32'h8, 32'h12345678, lat, dmw, err, rd, a1o);
    checks++; if (err !== 1'b1) $display("FAIL illegal_st_err: got %b expected 1", err); else passed++;
    checks++; if (lat !== 1) $display("FAIL illegal_st_latency: got %0d expected 1", lat); else passed++;
    checks++; if (dmw !== 0) $display("FAIL illegal_st_dm_w_cycles: got %0d expected 0", dmw); else passed++;
    finish_rsp();
    ref_exec(1'b0, DMT_W, 32'h8, 32'h0, eerr, erd, elat, edmw, eff);
    run_req(1'b0, DMT_W, 32'h8, 32'h0, lat, dmw, err, rd, a1o);
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL illegal_mem_unchanged: got %h expected deadbeef", rd); else passed++;
    finish_rsp();
    run_req(1'b0, 3'b010, 32'h4, 32'h0, lat, dmw, err, rd, a1o);
    checks++; if ({err, rd} !== {1'b1, 32'h0}) $display("FAIL illegal_type010: got err=%b rdata=%h expected err=1 rdata=0", err, rd); else passed++;
    finish_rsp();
  endtask

  task automatic test_stall();
    int lat, dmw, elat, edmw; logic err, eerr; logic [31:0] rd, erd, a1o, eff;
    ref_exec(1'b0, DMT_W, 32'h8, 32'h0, eerr, erd, elat, edmw, eff);
    run_req(1'b0, DMT_W, 32'h8, 32'h0, lat, dmw, err, rd, a1o);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, eerr, erd, 1'b0})
        $display("FAIL stall_cycle%0d: got valid=%b err=%b rdata=%h ready=%b expected valid=1 err=%b rdata=%h ready=0",
                 c, rsp_valid, rsp_err, rsp_rdata, req_ready, eerr, erd);
      else passed++;
    end
    finish_rsp();
    checks++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL stall_release: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid); else passed++;
  endtask

  task automatic test_reset_mid_hold();
    int elat, edmw; logic eerr; logic [31:0] erd, eff;
    logic seen;
    ref_exec(1'b1, DMT_W, 32'h10, 32'hCAFEF00D, eerr, erd, elat, edmw, eff);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_type = DMT_W; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({dm_w, a1} !== {1'b1, 32'h10}) $display("FAIL midhold_active: got dm_w=%b a1=%h expected dm_w=1 a1=00000010", dm_w, a1); else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({dm_w, dm_type, a1, wd, rsp_valid, rsp_rdata, rsp_err, req_ready} !== '0)
      $display("FAIL midhold_reset_outputs: got dm_w=%b type=%b a1=%h wd=%h valid=%b rdata=%h err=%b ready=%b expected all 0",
               dm_w, dm_type, a1, wd, rsp_valid, rsp_rdata, rsp_err, req_ready);
    else passed++;
    @(negedge clk);
    checks++; if ({req_ready, dm_w} !== 2'b00) $display("FAIL midhold_held: got ready=%b dm_w=%b expected 00", req_ready, dm_w); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL midhold_release_ready: got %b expected 1", req_ready); else passed++;
    seen = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (dm_w || rsp_valid || !req_ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midhold_no_replay: got activity=%b expected 0", seen); else passed++;
  endtask

  task automatic test_random();
    int lat, dmw, elat, edmw, stall; logic err, eerr, we, stable; logic [2:0] typ;
    logic [31:0] rd, erd, a1o, eff, addr, wdata;
    for (int n = 0; n < 40; n++) begin
      we    = 1'($urandom_range(0, 1));
      typ   = 3'($urandom_range(0, 7));
      addr  = 32'($urandom_range(0, 63));
      wdata = $urandom;
      stall = $urandom_range(0, 3);
      ref_exec(we, typ, addr, wdata, eerr, erd, elat, edmw, eff);
      run_req(we, typ, addr, wdata, lat, dmw, err, rd, a1o);
      checks++; if (lat !== elat) $display("FAIL rnd%0d_latency: got %0d expected %0d (we=%b type=%b addr=%h)", n, lat, elat, we, typ, addr); else passed++;
      checks++; if (dmw !== edmw) $display("FAIL rnd%0d_dm_w_cycles: got %0d expected %0d", n, dmw, edmw); else passed++;
      checks++; if (err !== eerr) $display("FAIL rnd%0d_err: got %b expected %b", n, err, eerr); else passed++;
      checks++; if (rd !== erd) $display("FAIL rnd%0d_rdata: got %h expected %h (type=%b addr=%h)", n, rd, erd, typ, addr); else passed++;
      if (!eerr) begin
        checks++; if (a1o !== eff) $display("FAIL rnd%0d_a1: got %h expected %h", n, a1o, eff); else passed++;
      end
      stable = 1'b1;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, eerr, erd, 1'b0}) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) $display("FAIL rnd%0d_stall_stable: got %b expected 1", n, stable); else passed++;
      finish_rsp();
      checks++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL rnd%0d_back_to_idle: got ready=%b valid=%b expected 1 0", n, req_ready, rsp_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_illegal();
    test_stall();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 5, number of cycles a data-memory access is held stable (min 2).
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  execute stage presents a memory request.
REQ-005 SHALL have port: req_ready  output  1  lsu_ctrl accepts the request this cycle.
REQ-006 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_type  input  3  access type: 000 w, 100 h, 101 hu, 110 b, 111 bu.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, low bits significant for h/b.
REQ-010 SHALL have port: dm_w, dm_type, a1, wd  output  1/3/32/32  drive the data-memory write-enable, type, address and write data.
REQ-011 SHALL have port: rd1  input  32  data-memory read result, already extended per dm_type.
REQ-012 SHALL have port: rsp_valid  output  1  response available.
REQ-013 SHALL have port: rsp_ready  input  1  writeback stage consumes the response.
REQ-014 SHALL have port: rsp_rdata  output  32  load data (0 for stores and errors).
REQ-015 SHALL have port: rsp_err  output  1  request was illegal or misaligned.

Function
- REQ-016 SHALL implement FSM IDLE -> HOLD -> RESP -> IDLE, one request outstanding at a time.
- REQ-017 SHALL assert req_ready only in IDLE; a request is accepted when req_valid & req_ready are both high on a rising edge.
- REQ-018 SHALL, on acceptance, register req_we/type/addr/wdata; outputs a1, dm_type and wd SHALL come from these registers only.
- REQ-019 SHALL flag illegal: type 001/010/011, or a store with type 101 or 111.
- REQ-020 SHALL flag misaligned: h/hu with addr[0]=1; w with addr[1:0]!=00.
- REQ-021 SHALL, for a legal request, stay in HOLD exactly WAIT_CYCLES cycles, using a down-counter loaded with WAIT_CYCLES-1 that moves to RESP at 0.
- REQ-022 SHALL, in HOLD, assert dm_w only for stores; dm_w SHALL be 0 in every other state.
- REQ-023 SHALL, for loads, capture rd1 into rsp_rdata on the last HOLD cycle.
- REQ-024 SHALL, for an illegal request, go IDLE -> RESP directly with rsp_err=1 and dm_w=0, so rsp_valid rises 1 cycle after acceptance.
- REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1; it SHALL then go to IDLE, with no zero-cycle bypass to a new acceptance.
- REQ-026 SHALL make the legal-access latency from acceptance to rsp_valid equal to WAIT_CYCLES+1 cycles.

Reset
- REQ-027 SHALL, on reset low at any time including mid-HOLD, force IDLE and the counter to 0, with dm_w=0, dm_type=000, a1=0, wd=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL be 0 while reset is low.
- REQ-028 SHALL NOT replay an aborted access after reset release; the first cycle after release is IDLE.

Configuration
- REQ-029 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat misaligned requests as illegal (REQ-024).
- REQ-030 SHALL, without LSU_MISALIGN_TRAP_EN, clear the offending low address bits (w: [1:0], h/hu: [0]), proceed normally, and never set rsp_err for misalignment.

Structure
- REQ-031 SHALL place the dm_type codes (DMT_W/H/HU/B/BU) and the FSM state encoding in shared package lsu_pkg; dm and lsu_ctrl SHALL both use it.
- REQ-032 SHALL put the combinational legality/alignment check in sub-module lsu_align_chk, with outputs illegal and masked_addr.

Verification
- REQ-033 SHALL test: store w, addr 0x8, data 0xDEADBEEF, then load w at 0x8 -> dm_w high for 5 cycles, load rsp_rdata=0xDEADBEEF, rsp_valid 6 cycles after acceptance.
- REQ-034 SHALL test: store b 0xAA at 0x5, then load bu at 0x5 and load b at 0x5 -> 0x000000AA and 0xFFFFFFAA.
- REQ-035 SHALL test: load h at 0x3 -> with the macro, rsp_err=1 after 1 cycle and dm_w never high; without it, the access goes to 0x2 and rsp_err=0.
- REQ-036 SHALL test: store type 101 -> rsp_err=1 and memory unchanged (a following load returns the old value).
- REQ-037 SHALL test: reset low in the 3rd HOLD cycle of a store -> all outputs go to reset values immediately and req_ready=1 in the first cycle after release.
- REQ-038 SHALL test: rsp_ready held low for 4 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0.
